// File: rtl/id_ex_stage_reg_if.sv
// ID/EX pipeline bundle: decoded ID-stage fields in, registered EX-stage copies out.
interface id_ex_stage_reg_if #(
    parameter int XLEN    = 32,
    parameter int ALUOP_W = 4
);
    logic               ID_valid;
    logic [XLEN-1:0]    ID_pc;
    logic [4:0]         ID_Rs1;
    logic [4:0]         ID_Rs2;
    logic [4:0]         ID_rd;
    logic               ID_rs1_used;
    logic               ID_rs2_used;
    logic               ID_RegWrite;
    logic               ID_MemRead;
    logic               ID_MemWrite;
    logic               ID_MemtoReg;
    logic               ID_ALUSrc;
    logic [ALUOP_W-1:0] ID_ALUop;
    logic [XLEN-1:0]    ID_imm;
    logic [XLEN-1:0]    ID_rdata1;
    logic [XLEN-1:0]    ID_rdata2;

    logic               EX_valid;
    logic [XLEN-1:0]    EX_pc;
    logic [4:0]         EX_Rs1;
    logic [4:0]         EX_Rs2;
    logic [4:0]         EX_rd;
    logic               EX_rs1_used;
    logic               EX_rs2_used;
    logic               EX_RegWrite;
    logic               EX_MemRead;
    logic               EX_MemWrite;
    logic               EX_MemtoReg;
    logic               EX_ALUSrc;
    logic [ALUOP_W-1:0] EX_ALUop;
    logic [XLEN-1:0]    EX_imm;
    logic [XLEN-1:0]    EX_rdata1;
    logic [XLEN-1:0]    EX_rdata2;

    // Upstream decode side: drives ID fields, observes EX copies.
    modport master (
        output ID_valid, ID_pc, ID_Rs1, ID_Rs2, ID_rd, ID_rs1_used, ID_rs2_used,
               ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc,
               ID_ALUop, ID_imm, ID_rdata1, ID_rdata2,
        input  EX_valid, EX_pc, EX_Rs1, EX_Rs2, EX_rd, EX_rs1_used, EX_rs2_used,
               EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemtoReg, EX_ALUSrc,
               EX_ALUop, EX_imm, EX_rdata1, EX_rdata2
    );

    // Pipeline register side: consumes ID fields, produces EX copies.
    modport slave (
        input  ID_valid, ID_pc, ID_Rs1, ID_Rs2, ID_rd, ID_rs1_used, ID_rs2_used,
               ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc,
               ID_ALUop, ID_imm, ID_rdata1, ID_rdata2,
        output EX_valid, EX_pc, EX_Rs1, EX_Rs2, EX_rd, EX_rs1_used, EX_rs2_used,
               EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemtoReg, EX_ALUSrc,
               EX_ALUop, EX_imm, EX_rdata1, EX_rdata2
    );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection, flush bubbles,
// external-stall freeze and a saturating count of load-use bubbles.
module id_ex_stage_reg #(
    parameter int XLEN    = 32,
    parameter int ALUOP_W = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    id_ex_stage_reg_if.slave bus,
    input  logic             flush,
    input  logic             stall_ext,
    output logic             PC_write,
    output logic             IF_ID_write,
    output logic             load_use_stall,
    output logic [CNT_W-1:0] bubble_cnt
);

    typedef struct packed {
        logic               valid;
        logic [XLEN-1:0]    pc;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [4:0]         rd;
        logic               rs1_used;
        logic               rs2_used;
        logic               regwrite;
        logic               memread;
        logic               memwrite;
        logic               memtoreg;
        logic               alusrc;
        logic [ALUOP_W-1:0] aluop;
        logic [XLEN-1:0]    imm;
        logic [XLEN-1:0]    rdata1;
        logic [XLEN-1:0]    rdata2;
    } stage_t;

    // An all-zero stage is a bubble: zero Rs/rd keeps forwarding from matching it.
    stage_t           id_s;
    stage_t           ex_q;
    stage_t           ex_d;
    logic [CNT_W-1:0] cnt_d;
    logic             hz;

    // Gather ID inputs and detect a load in EX feeding an operand used in ID.
    always_comb begin
        id_s.valid    = bus.ID_valid;
        id_s.pc       = bus.ID_pc;
        id_s.rs1      = bus.ID_Rs1;
        id_s.rs2      = bus.ID_Rs2;
        id_s.rd       = bus.ID_rd;
        id_s.rs1_used = bus.ID_rs1_used;
        id_s.rs2_used = bus.ID_rs2_used;
        id_s.regwrite = bus.ID_RegWrite;
        id_s.memread  = bus.ID_MemRead;
        id_s.memwrite = bus.ID_MemWrite;
        id_s.memtoreg = bus.ID_MemtoReg;
        id_s.alusrc   = bus.ID_ALUSrc;
        id_s.aluop    = bus.ID_ALUop;
        id_s.imm      = bus.ID_imm;
        id_s.rdata1   = bus.ID_rdata1;
        id_s.rdata2   = bus.ID_rdata2;

        hz = ex_q.valid && ex_q.memread && (ex_q.rd != 5'd0) && bus.ID_valid &&
             ((bus.ID_rs1_used && (bus.ID_Rs1 == ex_q.rd)) ||
              (bus.ID_rs2_used && (bus.ID_Rs2 == ex_q.rd)));
    end

    assign load_use_stall = hz & ~flush & ~stall_ext;
    // Front end always runs while reset is held, regardless of stall_ext.
    assign PC_write       = ~rst_n | ~(load_use_stall | stall_ext);
    assign IF_ID_write    = PC_write;

    // Next EX contents and bubble count: freeze > flush > load-use bubble > capture.
    always_comb begin
        ex_d  = ex_q;
        cnt_d = bubble_cnt;
        if (stall_ext) begin
            ex_d = ex_q;
        end else if (flush) begin
            ex_d = '0;
        end else if (load_use_stall) begin
            ex_d = '0;
            if (bubble_cnt != '1) begin
                cnt_d = bubble_cnt + 1'b1;
            end
        end else if (bus.ID_valid) begin
            ex_d = id_s;
        end else begin
            ex_d = '0;
        end
    end

    // EX stage register and bubble counter, asynchronously cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q       <= '0;
            bubble_cnt <= '0;
        end else begin
            ex_q       <= ex_d;
            bubble_cnt <= cnt_d;
        end
    end

    assign bus.EX_valid    = ex_q.valid;
    assign bus.EX_pc       = ex_q.pc;
    assign bus.EX_Rs1      = ex_q.rs1;
    assign bus.EX_Rs2      = ex_q.rs2;
    assign bus.EX_rd       = ex_q.rd;
    assign bus.EX_rs1_used = ex_q.rs1_used;
    assign bus.EX_rs2_used = ex_q.rs2_used;
    assign bus.EX_RegWrite = ex_q.regwrite;
    assign bus.EX_MemRead  = ex_q.memread;
    assign bus.EX_MemWrite = ex_q.memwrite;
    assign bus.EX_MemtoReg = ex_q.memtoreg;
    assign bus.EX_ALUSrc   = ex_q.alusrc;
    assign bus.EX_ALUop    = ex_q.aluop;
    assign bus.EX_imm      = ex_q.imm;
    assign bus.EX_rdata1   = ex_q.rdata1;
    assign bus.EX_rdata2   = ex_q.rdata2;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed table-driven bench for id_ex_stage_reg plus hand-written corner sequences.
module tb_id_ex_stage_reg;

    localparam int XLEN    = 32;
    localparam int ALUOP_W = 4;
    localparam int CNT_W   = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             stall_ext;
    logic             PC_write;
    logic             IF_ID_write;
    logic             load_use_stall;
    logic [CNT_W-1:0] bubble_cnt;

    int checks = 0;
    int errors = 0;

    id_ex_stage_reg_if #(.XLEN(XLEN), .ALUOP_W(ALUOP_W)) bus ();

    id_ex_stage_reg #(.XLEN(XLEN), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .flush          (flush),
        .stall_ext      (stall_ext),
        .PC_write       (PC_write),
        .IF_ID_write    (IF_ID_write),
        .load_use_stall (load_use_stall),
        .bubble_cnt     (bubble_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic        u1, u2, rw, mr, fl, se;
        logic        lus, pcw;
        logic        ev;
        logic [4:0]  erd, ers1, ers2;
        logic        emr, erw;
        logic [31:0] epc;
        logic [3:0]  ecnt;
    } vec_t;

    vec_t vecs[21];

    function automatic vec_t mk(
        input logic v, input logic [31:0] pc, input logic [4:0] rs1, rs2, rd,
        input logic u1, u2, rw, mr, fl, se, lus, pcw,
        input logic ev, input logic [4:0] erd, ers1, ers2,
        input logic emr, erw, input logic [31:0] epc, input logic [3:0] ecnt);
        vec_t r;
        r.v = v; r.pc = pc; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd;
        r.u1 = u1; r.u2 = u2; r.rw = rw; r.mr = mr; r.fl = fl; r.se = se;
        r.lus = lus; r.pcw = pcw; r.ev = ev; r.erd = erd; r.ers1 = ers1;
        r.ers2 = ers2; r.emr = emr; r.erw = erw; r.epc = epc; r.ecnt = ecnt;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Data-path fields are derived from the PC so expectations follow from epc alone.
    task automatic drive_id(
        input logic v, input logic [31:0] pc, input logic [4:0] rs1, rs2, rd,
        input logic u1, u2, rw, mr, fl, se);
        bus.ID_valid    = v;
        bus.ID_pc       = pc;
        bus.ID_Rs1      = rs1;
        bus.ID_Rs2      = rs2;
        bus.ID_rd       = rd;
        bus.ID_rs1_used = u1;
        bus.ID_rs2_used = u2;
        bus.ID_RegWrite = rw;
        bus.ID_MemRead  = mr;
        bus.ID_MemWrite = pc[2];
        bus.ID_MemtoReg = mr;
        bus.ID_ALUSrc   = pc[3];
        bus.ID_ALUop    = pc[5:2];
        bus.ID_imm      = pc ^ 32'h5A5A_0000;
        bus.ID_rdata1   = pc + 32'h1000;
        bus.ID_rdata2   = ~pc;
        flush           = fl;
        stall_ext       = se;
    endtask

    task automatic check_ex(
        input string tag, input logic ev, input logic [4:0] erd, ers1, ers2,
        input logic emr, erw, input logic [31:0] epc, input logic [3:0] ecnt);
        chk({tag, ".EX_valid"},    bus.EX_valid,    ev);
        chk({tag, ".EX_rd"},       bus.EX_rd,       erd);
        chk({tag, ".EX_Rs1"},      bus.EX_Rs1,      ers1);
        chk({tag, ".EX_Rs2"},      bus.EX_Rs2,      ers2);
        chk({tag, ".EX_MemRead"},  bus.EX_MemRead,  emr);
        chk({tag, ".EX_MemtoReg"}, bus.EX_MemtoReg, emr);
        chk({tag, ".EX_RegWrite"}, bus.EX_RegWrite, erw);
        chk({tag, ".EX_pc"},       bus.EX_pc,       epc);
        chk({tag, ".EX_imm"},      bus.EX_imm,      ev ? (epc ^ 32'h5A5A_0000) : 32'h0);
        chk({tag, ".EX_rdata1"},   bus.EX_rdata1,   ev ? (epc + 32'h1000) : 32'h0);
        chk({tag, ".EX_rdata2"},   bus.EX_rdata2,   ev ? ~epc : 32'h0);
        chk({tag, ".EX_ALUop"},    bus.EX_ALUop,    ev ? {28'h0, epc[5:2]} : 32'h0);
        chk({tag, ".EX_MemWrite"}, bus.EX_MemWrite, ev ? epc[2] : 1'b0);
        chk({tag, ".EX_ALUSrc"},   bus.EX_ALUSrc,   ev ? epc[3] : 1'b0);
        chk({tag, ".bubble_cnt"},  bubble_cnt,      ecnt);
    endtask

    initial begin
        // ID inst / controls                                         lus pcw | expected EX after edge
        vecs[0]  = mk(1, 'h100,  1, 0,  5, 1, 0, 1, 1, 0, 0,  0, 1,  1,  5,  1, 0, 1, 1, 'h100, 0);
        vecs[1]  = mk(1, 'h104,  5, 2,  6, 1, 1, 1, 0, 0, 0,  1, 0,  0,  0,  0, 0, 0, 0, 'h000, 1);
        vecs[2]  = mk(1, 'h104,  5, 2,  6, 1, 1, 1, 0, 0, 0,  0, 1,  1,  6,  5, 2, 0, 1, 'h104, 1);
        vecs[3]  = mk(1, 'h108,  3, 0,  0, 1, 0, 1, 1, 0, 0,  0, 1,  1,  0,  3, 0, 1, 1, 'h108, 1);
        vecs[4]  = mk(1, 'h10c,  0, 0,  7, 1, 1, 1, 0, 0, 0,  0, 1,  1,  7,  0, 0, 0, 1, 'h10c, 1);
        vecs[5]  = mk(1, 'h110,  2, 0,  5, 1, 0, 1, 1, 0, 0,  0, 1,  1,  5,  2, 0, 1, 1, 'h110, 1);
        vecs[6]  = mk(1, 'h114,  5, 5,  8, 0, 0, 1, 0, 0, 0,  0, 1,  1,  8,  5, 5, 0, 1, 'h114, 1);
        vecs[7]  = mk(1, 'h118,  1, 0,  9, 1, 0, 1, 1, 0, 0,  0, 1,  1,  9,  1, 0, 1, 1, 'h118, 1);
        vecs[8]  = mk(1, 'h11c,  1, 9, 10, 1, 1, 1, 0, 1, 0,  0, 1,  0,  0,  0, 0, 0, 0, 'h000, 1);
        vecs[9]  = mk(1, 'h120,  1, 0, 11, 1, 0, 1, 1, 0, 0,  0, 1,  1, 11,  1, 0, 1, 1, 'h120, 1);
        vecs[10] = mk(1, 'h124, 11, 3, 12, 1, 1, 1, 0, 0, 1,  0, 0,  1, 11,  1, 0, 1, 1, 'h120, 1);
        vecs[11] = mk(1, 'h124, 11, 3, 12, 1, 1, 1, 0, 0, 1,  0, 0,  1, 11,  1, 0, 1, 1, 'h120, 1);
        vecs[12] = mk(1, 'h124, 11, 3, 12, 1, 1, 1, 0, 0, 1,  0, 0,  1, 11,  1, 0, 1, 1, 'h120, 1);
        vecs[13] = mk(1, 'h124, 11, 3, 12, 1, 1, 1, 0, 0, 0,  1, 0,  0,  0,  0, 0, 0, 0, 'h000, 2);
        vecs[14] = mk(1, 'h124, 11, 3, 12, 1, 1, 1, 0, 0, 0,  0, 1,  1, 12, 11, 3, 0, 1, 'h124, 2);
        vecs[15] = mk(0, 'h128, 12, 0, 13, 1, 0, 1, 1, 0, 0,  0, 1,  0,  0,  0, 0, 0, 0, 'h000, 2);
        vecs[16] = mk(1, 'h12c,  1, 0, 14, 1, 0, 1, 1, 0, 0,  0, 1,  1, 14,  1, 0, 1, 1, 'h12c, 2);
        vecs[17] = mk(1, 'h130, 14, 0, 15, 1, 0, 1, 1, 0, 0,  1, 0,  0,  0,  0, 0, 0, 0, 'h000, 3);
        vecs[18] = mk(1, 'h130, 14, 0, 15, 1, 0, 1, 1, 0, 0,  0, 1,  1, 15, 14, 0, 1, 1, 'h130, 3);
        vecs[19] = mk(1, 'h134,  1, 15, 16, 1, 1, 1, 0, 0, 0,  1, 0,  0,  0,  0, 0, 0, 0, 'h000, 4);
        vecs[20] = mk(1, 'h134,  1, 15, 16, 1, 1, 1, 0, 0, 0,  0, 1,  1, 16,  1, 15, 0, 1, 'h134, 4);

        // Reset held with random ID inputs.
        rst_n = 1'b0;
        drive_id($urandom, $urandom, $urandom, $urandom, $urandom,
                 $urandom, $urandom, $urandom, $urandom, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.PC_write",       PC_write,          1'b1);
        chk("rst.IF_ID_write",    IF_ID_write,       1'b1);
        chk("rst.load_use_stall", load_use_stall,    1'b0);
        chk("rst.EX_rs1_used",    bus.EX_rs1_used,   1'b0);
        chk("rst.EX_rs2_used",    bus.EX_rs2_used,   1'b0);
        check_ex("rst", 0, 0, 0, 0, 0, 0, 32'h0, 4'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            drive_id(vecs[i].v, vecs[i].pc, vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
                     vecs[i].u1, vecs[i].u2, vecs[i].rw, vecs[i].mr, vecs[i].fl, vecs[i].se);
            #1;
            chk($sformatf("v%0d.load_use_stall", i), load_use_stall, vecs[i].lus);
            chk($sformatf("v%0d.PC_write", i),       PC_write,       vecs[i].pcw);
            chk($sformatf("v%0d.IF_ID_write", i),    IF_ID_write,    vecs[i].pcw);
            @(posedge clk);
            #1;
            check_ex($sformatf("v%0d", i), vecs[i].ev, vecs[i].erd, vecs[i].ers1, vecs[i].ers2,
                     vecs[i].emr, vecs[i].erw, vecs[i].epc, vecs[i].ecnt);
        end

        // Saturation: eleven more load-use bubbles bring the counter from 4 to 15,
        // and one more hazard must leave it at all-ones.
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            drive_id(1, 32'h200, 1, 0, 5, 1, 0, 1, 1, 0, 0);
            @(negedge clk);
            drive_id(1, 32'h204, 5, 0, 6, 1, 0, 1, 0, 0, 0);
            #1;
            chk($sformatf("sat%0d.load_use_stall", n), load_use_stall, 1'b1);
            @(posedge clk);
            #1;
            chk($sformatf("sat%0d.bubble_cnt", n), bubble_cnt, (n < 11) ? (5 + n) : 15);
            chk($sformatf("sat%0d.EX_valid", n), bus.EX_valid, 1'b0);
            @(negedge clk);
            #1;
            chk($sformatf("sat%0d.release", n), load_use_stall, 1'b0);
            @(posedge clk);
            #1;
            chk($sformatf("sat%0d.EX_rd", n), bus.EX_rd, 5'd6);
        end

        // Reset asserted in the middle of a load-use stall, with stall_ext also high.
        @(negedge clk);
        drive_id(1, 32'h300, 1, 0, 5, 1, 0, 1, 1, 0, 0);
        @(negedge clk);
        drive_id(1, 32'h304, 5, 0, 7, 1, 0, 1, 0, 0, 0);
        #1;
        chk("mid.load_use_stall", load_use_stall, 1'b1);
        stall_ext = 1'b1;
        rst_n     = 1'b0;
        #1;
        chk("mid.PC_write",       PC_write,       1'b1);
        chk("mid.load_use_stall", load_use_stall, 1'b0);
        check_ex("mid", 0, 0, 0, 0, 0, 0, 32'h0, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive_id(1, 32'h308, 2, 0, 5, 1, 0, 1, 0, 0, 0);
        @(posedge clk);
        #1;
        check_ex("post", 1, 5, 2, 0, 0, 1, 32'h308, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
